// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// It holds the 128-bit cipher state and applies one round for each round key it accepts.
// Keys 0..10 are requested over a valid/ready handshake. The ciphertext is then held until
// the consumer accepts it.
// Byte (row r, col c) of every 128-bit bus sits at bits [32c+8r +: 8].
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a block (sampled only when idle)
//   din        plaintext block
//   rk_req     round-key request (registered)
//   rk_idx     index of requested round key, 0..10 (registered)
//   rk_valid   key-schedule response valid
//   rk         round key for rk_idx
//   busy       high whenever not idle
//   out_valid  ciphertext valid
//   dout       ciphertext (registered, holds after handoff)
//   out_ready  consumer accepts dout
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] din,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk,
  output logic         busy,
  output logic         out_valid,
  output logic [127:0] dout,
  input  logic         out_ready
);

  typedef enum logic [1:0] {StIdle, StKey, StDone} state_e;

  localparam logic [3:0] LastRound = 4'd10;

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = Sbox[s[8*i +: 8]];
    end
    return o;
  endfunction

  // Row r rotates left by r columns: new col c takes old col (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] sr_out, mc_out, round_out;

  // Round datapath; key 0 is the initial AddRoundKey, key 10 skips MixColumns.
  always_comb begin
    sr_out = shift_rows(sub_bytes(state_q));
    mc_out = mix_columns(sr_out);
    if (idx_q == 4'd0) begin
      round_out = state_q ^ rk;
    end else if (idx_q == LastRound) begin
      round_out = sr_out ^ rk;
    end else begin
      round_out = mc_out ^ rk;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    unique case (fsm_q)
      StIdle: begin
        if (start) begin
          state_d = din;
          idx_d   = 4'd0;
          fsm_d   = StKey;
        end
      end
      StKey: begin
        if (rk_valid) begin
          state_d = round_out;
          if (idx_q == LastRound) begin
            dout_d = round_out;
            fsm_d  = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
    end
  end

  assign rk_req    = (fsm_q == StKey);
  assign busy      = (fsm_q != StIdle);
  assign out_valid = (fsm_q == StDone);
  assign rk_idx    = idx_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: a byte-level AES model (S-box derived from GF(2^8)
// inversion) tracks expected outputs every cycle; directed tests pin FIPS-197 vectors,
// key stalls, back-pressure, ignored starts, mid-block reset and back-to-back blocks.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid = 1'b1;
  logic [127:0] rk;
  logic         busy;
  logic         out_valid;
  logic [127:0] dout;
  logic         out_ready = 1'b1;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk        (rk),
    .busy      (busy),
    .out_valid (out_valid),
    .dout      (dout),
    .out_ready (out_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  int stall_left = 0;
  int total_stall = 0;
  bit stall_mode = 1'b0;
  bit use_zero = 1'b0;

  logic [7:0]   sbox_t [256];
  logic [127:0] kc [11];
  logic [127:0] kz [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // FIPS hex order (first byte leftmost) to bus layout (byte i at [8i +: 8]).
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[127-8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] get_rk(input logic [3:0] idx, input bit z);
    if (idx > 4'd10) return '0;
    return z ? kz[idx] : kc[idx];
  endfunction

  assign rk = get_rk(rk_idx, use_zero);

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key,
                                                input int rnd);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = st[8*i +: 8];
    if (rnd == 0) begin
      t = s;
    end else begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ key[8*i +: 8];
    return o;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input bit z);
    logic [127:0] st;
    st = pt;
    for (int r = 0; r <= 10; r++) st = model_round(st, z ? kz[r] : kc[r], r);
    return st;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(v[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input bit z);
    logic [7:0]   w [176];
    logic [7:0]   t [4];
    logic [7:0]   tmp, rc;
    logic [127:0] k;
    for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox_t[t[1]] ^ rc;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[tmp];
        rc   = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
    end
    for (int r = 0; r < 11; r++) begin
      for (int j = 0; j < 16; j++) k[8*j +: 8] = w[16*r+j];
      if (z) kz[r] = k;
      else kc[r] = k;
    end
  endtask

  // Behavioural model: phase 0 idle, 1 collecting keys, 2 holding ciphertext.
  int           m_phase = 0;
  int           m_idx = 0;
  logic [127:0] m_st = '0;
  logic [127:0] m_dout = '0;
  bit           m_init = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
      m_st    <= '0;
      m_dout  <= '0;
      m_init  <= 1'b1;
    end else if (m_init) begin
      if (m_phase == 0) begin
        if (start) begin
          m_st    <= din;
          m_idx   <= 0;
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        if (rk_valid) begin
          m_st <= model_round(m_st, get_rk(m_idx[3:0], use_zero), m_idx);
          if (m_idx == 10) begin
            m_dout  <= model_round(m_st, get_rk(m_idx[3:0], use_zero), m_idx);
            m_phase <= 2;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
      end else if (out_ready) begin
        m_phase <= 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("busy", busy, m_phase != 0);
      chk("rk_req", rk_req, m_phase == 1);
      chk("rk_idx", rk_idx, m_idx[3:0]);
      chk("out_valid", out_valid, m_phase == 2);
      chk("dout", dout, m_dout);
    end
  end

  // Key-schedule responder: optional random stall before each key.
  initial forever begin
    @(negedge clk);
    if (rk_req === 1'b1) begin
      if (stall_left > 0) begin
        rk_valid = 1'b0;
        stall_left--;
        total_stall++;
      end else begin
        rk_valid = 1'b1;
        stall_left = stall_mode ? int'($urandom_range(0, 5)) : 0;
      end
    end else begin
      rk_valid = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Call at a negedge; returns at the negedge of the cycle after start.
  task automatic pulse_start(input logic [127:0] d);
    din = d;
    start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ov(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_reached", out_valid, 1'b1);
  endtask

  task automatic wait_idx(input logic [3:0] k);
    int n = 0;
    while (rk_idx !== k && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rk_idx_reached", rk_idx, k);
  endtask

  logic [127:0] pt_c1, key_c1, ct_c1, ct_zero, other;
  int lat, t1;

  initial begin
    pt_c1   = bswap(128'h00112233445566778899aabbccddeeff);
    key_c1  = bswap(128'h000102030405060708090a0b0c0d0e0f);
    ct_c1   = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ct_zero = bswap(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    other   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    build_sbox();
    expand(key_c1, 1'b0);
    expand('0, 1'b1);

    // Pin the model with hand-known values.
    chk("model_sbox_00", sbox_t[0], 8'h63);
    chk("model_sbox_53", sbox_t[8'h53], 8'hed);
    chk("model_rk10", kc[10], bswap(128'h13111d7fe3944a17f307a78b4d2b30c5));
    chk("model_c1", aes_encrypt(pt_c1, 1'b0), ct_c1);
    chk("model_zero", aes_encrypt('0, 1'b1), ct_zero);

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_rk_req", rk_req, 1'b0);
    chk("reset_rk_idx", rk_idx, 4'd0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_dout", dout, '0);

    // C.1 vector, keys always valid.
    pulse_start(pt_c1);
    wait_ov(lat);
    chk("c1_latency", lat, 12);
    chk("c1_dout", dout, ct_c1);
    repeat (2) tick();

    // Random key stalls.
    stall_mode = 1'b1;
    total_stall = 0;
    stall_left = $urandom_range(0, 5);
    pulse_start(pt_c1);
    wait_ov(lat);
    chk("stall_latency", lat, 12 + total_stall);
    chk("stall_dout", dout, ct_c1);
    stall_mode = 1'b0;
    stall_left = 0;
    repeat (2) tick();

    // Output back-pressure with an ignored start.
    out_ready = 1'b0;
    pulse_start(pt_c1);
    wait_ov(lat);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_dout", dout, ct_c1);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_busy", busy, 1'b1);
      if (i == 5) begin
        din = other;
        start = 1'b1;
      end
      if (i == 6) start = 1'b0;
    end
    out_ready = 1'b1;
    start = 1'b1;
    din = other;
    tick();
    start = 1'b0;
    chk("bp_idle_ov", out_valid, 1'b0);
    chk("bp_idle_busy", busy, 1'b0);
    chk("bp_dout_kept", dout, ct_c1);
    tick();
    chk("bp_start_ignored", busy, 1'b0);

    // Start while busy.
    pulse_start(pt_c1);
    wait_idx(4'd5);
    din = other;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ov(lat);
    chk("busy_start_dout", dout, ct_c1);
    repeat (2) tick();

    // Reset mid-block.
    pulse_start(pt_c1);
    wait_idx(4'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rk_req", rk_req, 1'b0);
    chk("mid_rst_rk_idx", rk_idx, 4'd0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_dout", dout, '0);
    tick();
    pulse_start(pt_c1);
    wait_ov(lat);
    chk("post_rst_latency", lat, 12);
    chk("post_rst_dout", dout, ct_c1);
    repeat (2) tick();

    // Back-to-back blocks.
    pulse_start(pt_c1);
    t1 = t_start;
    wait_ov(lat);
    chk("b2b_first_dout", dout, ct_c1);
    tick();
    use_zero = 1'b1;
    pulse_start('0);
    chk("b2b_period", t_start - t1, 13);
    wait_ov(lat);
    chk("b2b_latency", lat, 12);
    chk("b2b_zero_dout", dout, ct_zero);
    repeat (2) tick();
    use_zero = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
